// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single FIFO write port among NUM_REQ requesters in the write-clock
//   domain. A round-robin scan picks a requester; after its first beat the winner
//   holds the port for up to MAX_BURST consecutive beats. A beat is accepted and
//   written in the same cycle it is granted, and never while the FIFO reports full.
//
// Ports
//   clk        in   write clock (FIFO w_clk)
//   reset      in   synchronous, active-high
//   req_valid  in   [NUM_REQ]             requester i has a word
//   req_data   in   [NUM_REQ*DATA_WIDTH]  word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  [NUM_REQ]             word i accepted this cycle
//   w_full     in   FIFO full flag
//   w_data     out  [DATA_WIDTH]          word written to the FIFO
//   w_inc      out  FIFO write strobe
//   grant_vld  out  a requester is granted this cycle
//   grant_id   out  [$clog2(NUM_REQ)]     index of the granted requester

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          w_full,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic                          w_inc,
    output logic                          grant_vld,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    localparam logic [IDW:0]    NREQ_W    = (IDW + 1)'(NUM_REQ);
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          r_state, w_state_nxt;
    logic [IDW-1:0]  r_owner, w_owner_nxt;
    logic [IDW-1:0]  r_rr_ptr, w_rr_nxt;
    logic [CNTW-1:0] r_beat_cnt, w_beat_nxt;

    logic [IDW:0]            w_scan_sum;
    logic [IDW-1:0]          w_scan_g;
    logic                    w_scan_hit;
    logic [IDW-1:0]          w_g;
    logic                    w_gvld;
    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_word;

    // Successor index with wrap at NUM_REQ-1 (NUM_REQ need not be a power of two).
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == IDW'(NUM_REQ - 1)) ? '0 : i + IDW'(1);
    endfunction

    // Round-robin scan starting at r_rr_ptr; the first valid requester wins.
    always_comb begin
        w_scan_g   = '0;
        w_scan_hit = 1'b0;
        w_scan_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
            if (w_scan_sum >= NREQ_W) begin
                w_scan_sum = w_scan_sum - NREQ_W;
            end
            if (!w_scan_hit && req_valid[w_scan_sum[IDW-1:0]]) begin
                w_scan_g   = w_scan_sum[IDW-1:0];
                w_scan_hit = 1'b1;
            end
        end
    end

    // While locked the owner keeps the port even if others are waiting.
    always_comb begin
        if (r_state == LOCKED) begin
            w_g    = r_owner;
            w_gvld = req_valid[r_owner];
        end else begin
            w_g    = w_scan_g;
            w_gvld = |req_valid;
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_g == IDW'(i)) begin
                w_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Outputs are forced quiet during reset so a word presented in a reset
    // cycle is neither written nor acknowledged.
    assign w_xfer    = w_gvld & ~w_full & ~reset;
    assign w_inc     = w_xfer;
    assign grant_vld = w_gvld & ~reset;
    assign grant_id  = grant_vld ? w_g : '0;
    assign w_data    = grant_vld ? w_word : '0;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_xfer && (w_g == IDW'(i));
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (MAX_BURST == 1) begin
                        w_rr_nxt = next_idx(w_g);
                    end else begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_g;
                        w_beat_nxt  = CNTW'(1);
                    end
                end
            end
            LOCKED: begin
                // An owner that drops valid gives up the rest of its burst.
                if (!req_valid[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = next_idx(r_owner);
                    w_beat_nxt  = '0;
                end else if (w_xfer) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = next_idx(r_owner);
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat_cnt + CNTW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    a_no_write_when_full : assert property (@(posedge clk) disable iff (reset)
        !(w_inc && w_full));
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));
    a_inc_matches_ready : assert property (@(posedge clk) disable iff (reset)
        w_inc == (|req_ready));
    a_beat_in_range : assert property (@(posedge clk) disable iff (reset)
        r_beat_cnt < CNTW'(MAX_BURST));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        w_full;
    logic [3:0]  w_data;
    logic        w_inc;
    logic        grant_vld;
    logic [1:0]  grant_id;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(4),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .w_full    (w_full),
        .w_data    (w_data),
        .w_inc     (w_inc),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    typedef struct {
        logic [1:0] id;
        logic [3:0] data;
    } wr_t;

    typedef struct {
        int         cyc;
        logic       inc;
        logic       vld;
        logic [1:0] id;
        logic [3:0] data;
        logic [3:0] rdy;
    } obs_t;

    wr_t  wr_q[$];
    obs_t obs_q[$];

    int   n_chk;
    int   n_fail;
    int   cyc_cnt;
    logic tb_done;
    logic fin_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: pops expected writes whenever the DUT writes, and expected
    // per-cycle observations tagged with the cycle they belong to.
    always @(negedge clk) begin
        if (w_inc) begin
            n_chk = n_chk + 1;
            if (wr_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_write cyc=%0d id=%0d data=%h (no write required)",
                         cyc_cnt, grant_id, w_data);
            end else begin
                wr_t        e;
                logic [3:0] er;
                e  = wr_q.pop_front();
                er = 4'b0001 << e.id;
                if (grant_id !== e.id || w_data !== e.data || req_ready !== er || grant_vld !== 1'b1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL write cyc=%0d got id=%0d data=%h rdy=%b vld=%b required id=%0d data=%h rdy=%b vld=1",
                             cyc_cnt, grant_id, w_data, req_ready, grant_vld, e.id, e.data, er);
                end
            end
        end
        if (obs_q.size() > 0 && obs_q[0].cyc == cyc_cnt) begin
            obs_t o;
            o = obs_q.pop_front();
            n_chk = n_chk + 1;
            if (w_inc !== o.inc || grant_vld !== o.vld || grant_id !== o.id ||
                w_data !== o.data || req_ready !== o.rdy) begin
                n_fail = n_fail + 1;
                $display("FAIL obs cyc=%0d got inc=%b vld=%b id=%0d data=%h rdy=%b required inc=%b vld=%b id=%0d data=%h rdy=%b",
                         cyc_cnt, w_inc, grant_vld, grant_id, w_data, req_ready,
                         o.inc, o.vld, o.id, o.data, o.rdy);
            end
        end
        if (tb_done && !fin_done) begin
            fin_done = 1'b1;
            n_chk = n_chk + 1;
            if (wr_q.size() != 0) begin
                n_fail = n_fail + 1;
                $display("FAIL missing_writes got %0d outstanding required 0", wr_q.size());
            end
        end
    end

    task automatic drive(input logic rst, input logic [3:0] v, input logic [15:0] d, input logic f);
        @(posedge clk);
        #1;
        reset     = rst;
        req_valid = v;
        req_data  = d;
        w_full    = f;
    endtask

    task automatic exp_wr(input logic [1:0] id, input logic [3:0] data);
        wr_t e;
        e.id   = id;
        e.data = data;
        wr_q.push_back(e);
    endtask

    task automatic exp_obs(input logic inc, input logic vld, input logic [1:0] id,
                           input logic [3:0] data, input logic [3:0] rdy);
        obs_t o;
        o.cyc  = cyc_cnt;
        o.inc  = inc;
        o.vld  = vld;
        o.id   = id;
        o.data = data;
        o.rdy  = rdy;
        obs_q.push_back(o);
    endtask

    task automatic do_reset();
        drive(1'b1, 4'h0, 16'h0000, 1'b0);
        drive(1'b1, 4'h0, 16'h0000, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout reached without summary");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        cyc_cnt   = 0;
        tb_done   = 1'b0;
        fin_done  = 1'b0;
        reset     = 1'b1;
        req_valid = 4'hF;
        req_data  = 16'hCBA9;
        w_full    = 1'b0;

        // Reset held with every requester valid: outputs all zero.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'hF, 16'hCBA9, 1'b0);
            exp_obs(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        end

        // All four valid continuously: bursts of four in round-robin order,
        // starting with requester 0. Words: r0=9 r1=A r2=B r3=C.
        for (int k = 0; k < 17; k++) begin
            drive(1'b0, 4'hF, 16'hCBA9, 1'b0);
            exp_wr(2'((k / 4) % 4), 4'(9 + (k / 4) % 4));
        end
        do_reset();

        // Only requester 2, words 1..6, no bubble across the burst boundary.
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 4'b0100, {4'h0, 4'(k), 8'h00}, 1'b0);
            exp_wr(2'd2, 4'(k));
        end
        drive(1'b0, 4'b0000, 16'h0000, 1'b0);
        exp_obs(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        do_reset();

        // Requester 1 locked; FIFO full for 3 cycles after beat 2.
        drive(1'b0, 4'b0110, 16'h0710, 1'b0); exp_wr(2'd1, 4'h1);
        drive(1'b0, 4'b0110, 16'h0720, 1'b0); exp_wr(2'd1, 4'h2);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b0110, 16'h0730, 1'b1);
            exp_obs(1'b0, 1'b1, 2'd1, 4'h3, 4'h0);
        end
        drive(1'b0, 4'b0110, 16'h0730, 1'b0); exp_wr(2'd1, 4'h3);
        drive(1'b0, 4'b0110, 16'h0740, 1'b0); exp_wr(2'd1, 4'h4);
        drive(1'b0, 4'b0110, 16'h0750, 1'b0); exp_wr(2'd2, 4'h7);
        do_reset();

        // Requester 3 drops valid after beat 1: release with no write, then
        // the pointer wraps to 0 so requester 0 beats the re-raised requester 3.
        drive(1'b0, 4'b1000, 16'h6000, 1'b0); exp_wr(2'd3, 4'h6);
        drive(1'b0, 4'b0001, 16'h0002, 1'b0);
        exp_obs(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        drive(1'b0, 4'b1001, 16'h9002, 1'b0); exp_wr(2'd0, 4'h2);
        do_reset();

        // Reset pulse on beat 2 of requester 1 aborts the lock.
        drive(1'b0, 4'b0010, 16'h0010, 1'b0); exp_wr(2'd1, 4'h1);
        drive(1'b1, 4'b0010, 16'h0020, 1'b0);
        exp_obs(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        drive(1'b0, 4'hF, 16'h6524, 1'b0); exp_wr(2'd0, 4'h4);
        do_reset();

        tb_done = 1'b1;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
